branch_predictor_btb: RTL and testbench
=======================================

Name: branch_predictor_btb

Overview:
- Bimodal direction predictor with a direct-mapped branch target buffer.
- Sits beside fetch. It drives the branch-prediction bundle (valid, target, prediction) for the current fetch PC.
- It consumes the branch-resolution bundle from decode to train its tables.
- It keeps saturating statistics counters for resolved branches and mispredictions.

Parameters:
- ADDR_WIDTH, 32, address width; matches `ADDR_WIDTH.
- INDEX_BITS, 6, log2 of the number of entries (64).
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; active-low, synchronous.
- i_fetch_pc  in  ADDR_WIDTH  PC being fetched this cycle.
- o_pred_valid  out  1  BTB hit; the instruction is a known branch.
- o_pred_target  out  ADDR_WIDTH  predicted target.
- o_pred_taken  out  1  BranchOutcome: 1=TAKEN, 0=NOT_TAKEN.
- i_res_valid  in  1  decode resolved a branch/jump this cycle.
- i_res_pc  in  ADDR_WIDTH  PC of the resolved instruction.
- i_res_target  in  ADDR_WIDTH  decoded target.
- i_res_prediction  in  1  prediction that travelled with the instruction.
- i_res_outcome  in  1  evaluated outcome.
- i_invalidate  in  1  clear all BTB entries.
- o_resolved_count  out  CNT_WIDTH  number of resolutions seen.
- o_mispredict_count  out  CNT_WIDTH  number of resolutions where prediction != outcome.

Behaviour:
- Addressing:
  - index = pc[INDEX_BITS+1:2].
  - tag = pc[ADDR_WIDTH-1:INDEX_BITS+2].
  - pc[1:0] is ignored.
- Entry contents: valid, tag, target, and a 2-bit counter ctr (0=strong NT, 1=weak NT, 2=weak T, 3=strong T).
- Prediction (combinational from registered state, zero latency):
  - hit = entry[idx(i_fetch_pc)].valid && tag match.
  - o_pred_valid = hit.
  - o_pred_target = hit ? entry target : 0.
  - o_pred_taken = hit && ctr[1].
- Update (registered at posedge clk when i_res_valid), entry selected by i_res_pc:
  - Hit, outcome TAKEN: ctr = min(ctr+1, 3); target = i_res_target.
  - Hit, outcome NOT_TAKEN: ctr = max(ctr-1, 0); target unchanged.
  - Miss, outcome TAKEN: allocate (overwrite any occupant): valid=1, tag from i_res_pc, target=i_res_target, ctr=2.
  - Miss, outcome NOT_TAKEN: no table change.
- Statistics, each cycle i_res_valid=1:
  - o_resolved_count increments by 1.
  - o_mispredict_count increments by 1 if i_res_prediction != i_res_outcome.
  - Both counters saturate at 2^CNT_WIDTH-1; they never wrap.
- Read/write collision: when fetch and resolution hit the same index in the same cycle, the prediction uses the pre-update contents. The new contents are visible the next cycle.
- Invalidate:
  - i_invalidate=1 clears every valid bit at the next edge.
  - It takes priority over a simultaneous update; that update is discarded.
  - Statistics are unaffected by invalidate; a resolution in the same cycle is still counted.
- Reset (rst_n=0 at posedge):
  - All valid bits clear and all ctr=0.
  - Both statistics counters = 0.
  - Outputs after reset: o_pred_valid=0, o_pred_target=0, o_pred_taken=0.
  - Reset overrides invalidate and update. Reset asserted mid-operation discards any update in that cycle.
- No stall input. Fetch stalls merely hold i_fetch_pc; training is independent of pipeline stalls.
- Aliasing: PCs with equal index and different tag evict each other only on a TAKEN allocation.

Test Plan:
1. Reset, then i_fetch_pc=0x00400010 -> o_pred_valid=0, o_pred_taken=0, o_pred_target=0; both counts 0.
2. Resolve pc=0x00400010, target=0x00400040, outcome=T, pred=NT; next cycle fetch 0x00400010 -> valid=1, taken=1 (ctr=2), target=0x00400040; resolved=1, mispredict=1.
3. From scenario 2, resolve the same PC NT three times -> ctr goes 1, 0, 0; fetch shows valid=1, taken=0 and the target is unchanged. A further T resolution -> ctr=1, still predicts NT.
4. Alias: entry at 0x00400010, then resolve pc=0x00401010 (same index 4, different tag) NT -> original entry still hits; resolve 0x00401010 T, target 0x00401100 -> fetch 0x00400010 misses and fetch 0x00401010 hits.
5. Same-cycle i_invalidate=1 and i_res_valid=1 (T, new PC) -> no entry hits afterwards; resolved_count still increments.
6. Saturation with CNT_WIDTH=4: 20 mispredicting resolutions -> both counts hold at 15. Pulsing rst_n=0 for one cycle mid-stream -> counts 0 and all entries miss.

Source files
------------

// File: rtl/branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_btb
// Purpose  : Bimodal direction predictor with a direct-mapped branch target
//            buffer. Gives a zero-latency prediction for the fetch PC from
//            registered table state and trains on branch resolutions. It also
//            keeps saturating counts of resolutions and mispredictions.
// Ports    : clk, rst_n (sync, active-low)
//            i_fetch_pc                    -> o_pred_valid/target/taken
//            i_res_valid/pc/target/prediction/outcome : training bundle
//            i_invalidate                  : clear all BTB valid bits
//            o_resolved_count, o_mispredict_count : statistics
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor_btb #(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] i_fetch_pc,
    output logic                  o_pred_valid,
    output logic [ADDR_WIDTH-1:0] o_pred_target,
    output logic                  o_pred_taken,
    input  logic                  i_res_valid,
    input  logic [ADDR_WIDTH-1:0] i_res_pc,
    input  logic [ADDR_WIDTH-1:0] i_res_target,
    input  logic                  i_res_prediction,
    input  logic                  i_res_outcome,
    input  logic                  i_invalidate,
    output logic [CNT_WIDTH-1:0]  o_resolved_count,
    output logic [CNT_WIDTH-1:0]  o_mispredict_count
);

    localparam int                   c_ENTRIES = 1 << INDEX_BITS;
    localparam int                   c_TAG_W   = ADDR_WIDTH - INDEX_BITS - 2;
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    // Table state
    logic [c_ENTRIES-1:0]  r_valid_q;
    logic [c_ENTRIES-1:0]  w_valid_d;
    logic [c_TAG_W-1:0]    r_tag_q    [c_ENTRIES];
    logic [c_TAG_W-1:0]    w_tag_d    [c_ENTRIES];
    logic [ADDR_WIDTH-1:0] r_target_q [c_ENTRIES];
    logic [ADDR_WIDTH-1:0] w_target_d [c_ENTRIES];
    logic [1:0]            r_ctr_q    [c_ENTRIES];
    logic [1:0]            w_ctr_d    [c_ENTRIES];

    // Statistics
    logic [CNT_WIDTH-1:0]  r_resolved_q;
    logic [CNT_WIDTH-1:0]  w_resolved_d;
    logic [CNT_WIDTH-1:0]  r_mispredict_q;
    logic [CNT_WIDTH-1:0]  w_mispredict_d;

    logic [INDEX_BITS-1:0] w_fetch_idx;
    logic [c_TAG_W-1:0]    w_fetch_tag;
    logic                  w_fetch_hit;
    logic [INDEX_BITS-1:0] w_res_idx;
    logic [c_TAG_W-1:0]    w_res_tag;
    logic                  w_res_hit;

    // ------------------------------------------------------------------
    // Prediction: reads only registered state, so a same-cycle update to
    // the same index is seen by fetch one cycle later.
    // ------------------------------------------------------------------
    always_comb begin
        w_fetch_idx   = i_fetch_pc[INDEX_BITS+1:2];
        w_fetch_tag   = i_fetch_pc[ADDR_WIDTH-1:INDEX_BITS+2];
        w_fetch_hit   = r_valid_q[w_fetch_idx] && (r_tag_q[w_fetch_idx] == w_fetch_tag);
        o_pred_valid  = w_fetch_hit;
        o_pred_target = w_fetch_hit ? r_target_q[w_fetch_idx] : '0;
        o_pred_taken  = w_fetch_hit && r_ctr_q[w_fetch_idx][1];
    end

    // ------------------------------------------------------------------
    // Training next-state
    // ------------------------------------------------------------------
    always_comb begin
        w_res_idx  = i_res_pc[INDEX_BITS+1:2];
        w_res_tag  = i_res_pc[ADDR_WIDTH-1:INDEX_BITS+2];
        w_res_hit  = r_valid_q[w_res_idx] && (r_tag_q[w_res_idx] == w_res_tag);

        w_valid_d  = r_valid_q;
        w_tag_d    = r_tag_q;
        w_target_d = r_target_q;
        w_ctr_d    = r_ctr_q;

        if (i_invalidate) begin
            // Invalidate wins; a concurrent update is dropped.
            w_valid_d = '0;
        end else if (i_res_valid) begin
            if (w_res_hit) begin
                if (i_res_outcome) begin
                    if (r_ctr_q[w_res_idx] != 2'd3) begin
                        w_ctr_d[w_res_idx] = r_ctr_q[w_res_idx] + 2'd1;
                    end
                    w_target_d[w_res_idx] = i_res_target;
                end else if (r_ctr_q[w_res_idx] != 2'd0) begin
                    w_ctr_d[w_res_idx] = r_ctr_q[w_res_idx] - 2'd1;
                end
            end else if (i_res_outcome) begin
                // Taken miss allocates, evicting any aliasing occupant.
                w_valid_d[w_res_idx]  = 1'b1;
                w_tag_d[w_res_idx]    = w_res_tag;
                w_target_d[w_res_idx] = i_res_target;
                w_ctr_d[w_res_idx]    = 2'd2;
            end
        end
    end

    // Statistics are independent of invalidate.
    always_comb begin
        w_resolved_d   = r_resolved_q;
        w_mispredict_d = r_mispredict_q;
        if (i_res_valid) begin
            if (r_resolved_q != c_CNT_MAX) begin
                w_resolved_d = r_resolved_q + c_CNT_ONE;
            end
            if ((i_res_prediction != i_res_outcome) && (r_mispredict_q != c_CNT_MAX)) begin
                w_mispredict_d = r_mispredict_q + c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid_q      <= '0;
            r_resolved_q   <= '0;
            r_mispredict_q <= '0;
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_ctr_q[i] <= 2'd0;
            end
        end else begin
            r_valid_q      <= w_valid_d;
            r_resolved_q   <= w_resolved_d;
            r_mispredict_q <= w_mispredict_d;
            r_ctr_q        <= w_ctr_d;
        end
    end

    // Tag/target payload needs no reset: it is qualified by the valid bit.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_tag_q    <= w_tag_d;
            r_target_q <= w_target_d;
        end
    end

    assign o_resolved_count   = r_resolved_q;
    assign o_mispredict_count = r_mispredict_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor_btb
// Purpose  : Self-checking bench for branch_predictor_btb (CNT_WIDTH=4 so the
//            statistics saturate quickly). Directed scenarios followed by
//            randomized traffic, checked against a table-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_btb;

    localparam int c_AW  = 32;
    localparam int c_IB  = 6;
    localparam int c_CW  = 4;
    localparam int c_MAX = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [c_AW-1:0]   i_fetch_pc;
    logic              o_pred_valid;
    logic [c_AW-1:0]   o_pred_target;
    logic              o_pred_taken;
    logic              i_res_valid;
    logic [c_AW-1:0]   i_res_pc;
    logic [c_AW-1:0]   i_res_target;
    logic              i_res_prediction;
    logic              i_res_outcome;
    logic              i_invalidate;
    logic [c_CW-1:0]   o_resolved_count;
    logic [c_CW-1:0]   o_mispredict_count;

    branch_predictor_btb #(
        .ADDR_WIDTH (c_AW),
        .INDEX_BITS (c_IB),
        .CNT_WIDTH  (c_CW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_fetch_pc         (i_fetch_pc),
        .o_pred_valid       (o_pred_valid),
        .o_pred_target      (o_pred_target),
        .o_pred_taken       (o_pred_taken),
        .i_res_valid        (i_res_valid),
        .i_res_pc           (i_res_pc),
        .i_res_target       (i_res_target),
        .i_res_prediction   (i_res_prediction),
        .i_res_outcome      (i_res_outcome),
        .i_invalidate       (i_invalidate),
        .o_resolved_count   (o_resolved_count),
        .o_mispredict_count (o_mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        v;
        logic        tk;
        logic [31:0] tgt;
        logic [3:0]  rc;
        logic [3:0]  mc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: 64-entry table of plain ints
    bit          m_valid  [64];
    int unsigned m_tag    [64];
    int unsigned m_target [64];
    int          m_ctr    [64];
    int          m_res;
    int          m_mis;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> 8;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 0;
        end
        m_res = 0;
        m_mis = 0;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Monitor: drains every expectation queued for the current cycle
    exp_t e;
    always @(negedge clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            chk({e.name, ".valid"},  32'(o_pred_valid),       32'(e.v));
            chk({e.name, ".taken"},  32'(o_pred_taken),       32'(e.tk));
            chk({e.name, ".target"}, o_pred_target,           e.tgt);
            chk({e.name, ".resolved"},   32'(o_resolved_count),   32'(e.rc));
            chk({e.name, ".mispredict"}, 32'(o_mispredict_count), 32'(e.mc));
        end
    end

    // Apply one cycle of stimulus; queue the model prediction for this cycle
    // (pre-edge state), then advance the model across the coming edge.
    task automatic step(input bit rstn, input logic [31:0] fpc,
                        input bit rv, input logic [31:0] rpc, input logic [31:0] rtgt,
                        input bit rpred, input bit rout, input bit inv);
        exp_t x;
        int   fi, ri;
        bit   hit;
        @(posedge clk);
        #1;
        rst_n            = rstn;
        i_fetch_pc       = fpc;
        i_res_valid      = rv;
        i_res_pc         = rpc;
        i_res_target     = rtgt;
        i_res_prediction = rpred;
        i_res_outcome    = rout;
        i_invalidate     = inv;

        fi     = idx_of(fpc);
        hit    = m_valid[fi] && (m_tag[fi] == tag_of(fpc));
        x.name = "model";
        x.v    = hit;
        x.tk   = hit && (m_ctr[fi] >= 2);
        x.tgt  = hit ? m_target[fi] : 32'd0;
        x.rc   = 4'(m_res);
        x.mc   = 4'(m_mis);
        q.push_back(x);

        if (!rstn) begin
            model_reset();
        end else begin
            if (rv) begin
                m_res = (m_res + 1 > c_MAX) ? c_MAX : m_res + 1;
                if (rpred != rout) m_mis = (m_mis + 1 > c_MAX) ? c_MAX : m_mis + 1;
            end
            if (inv) begin
                for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
            end else if (rv) begin
                ri = idx_of(rpc);
                if (m_valid[ri] && m_tag[ri] == tag_of(rpc)) begin
                    if (rout) begin
                        m_ctr[ri]    = (m_ctr[ri] == 3) ? 3 : m_ctr[ri] + 1;
                        m_target[ri] = rtgt;
                    end else begin
                        m_ctr[ri] = (m_ctr[ri] == 0) ? 0 : m_ctr[ri] - 1;
                    end
                end else if (rout) begin
                    m_valid[ri]  = 1'b1;
                    m_tag[ri]    = tag_of(rpc);
                    m_target[ri] = rtgt;
                    m_ctr[ri]    = 2;
                end
            end
        end
    endtask

    // Hand-derived expectation for the cycle just driven
    task automatic expect_c(input string n, input bit v, input bit tk, input logic [31:0] tgt,
                            input int rc, input int mc);
        exp_t x;
        x.name = n;
        x.v    = v;
        x.tk   = tk;
        x.tgt  = tgt;
        x.rc   = 4'(rc);
        x.mc   = 4'(mc);
        q.push_back(x);
    endtask

    task automatic fetch(input logic [31:0] fpc);
        step(1'b1, fpc, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resolve(input logic [31:0] fpc, input logic [31:0] rpc, input logic [31:0] rtgt,
                           input bit rpred, input bit rout);
        step(1'b1, fpc, 1'b1, rpc, rtgt, rpred, rout, 1'b0);
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'h0040_0000 | (32'($urandom_range(0, 7)) << 2)
             | (32'($urandom_range(0, 2)) << 8) | 32'($urandom_range(0, 3));
    endfunction

    localparam logic [31:0] c_PC_A  = 32'h0040_0010;
    localparam logic [31:0] c_TGT_A = 32'h0040_0040;
    localparam logic [31:0] c_PC_B  = 32'h0040_1010;
    localparam logic [31:0] c_TGT_B = 32'h0040_1100;
    localparam logic [31:0] c_PC_C  = 32'h0040_0020;

    initial begin
        rst_n = 1'b0; i_fetch_pc = '0; i_res_valid = 1'b0; i_res_pc = '0;
        i_res_target = '0; i_res_prediction = 1'b0; i_res_outcome = 1'b0; i_invalidate = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        // 1: reset state
        fetch(c_PC_A);
        expect_c("reset", 0, 0, 0, 0, 0);

        // 2: allocate; same-cycle fetch sees pre-update contents
        resolve(c_PC_A, c_PC_A, c_TGT_A, 1'b0, 1'b1);
        expect_c("collide", 0, 0, 0, 0, 0);
        fetch(c_PC_A);
        expect_c("alloc", 1, 1, c_TGT_A, 1, 1);

        // 3: decrement to strong NT, then one taken -> weak NT
        resolve(c_PC_A, c_PC_A, 32'hDEAD_0000, 1'b1, 1'b0);
        resolve(c_PC_A, c_PC_A, 32'hDEAD_0000, 1'b0, 1'b0);
        resolve(c_PC_A, c_PC_A, 32'hDEAD_0000, 1'b0, 1'b0);
        fetch(c_PC_A);
        expect_c("ctr_floor", 1, 0, c_TGT_A, 4, 2);
        resolve(c_PC_A, c_PC_A, c_TGT_A, 1'b0, 1'b1);
        fetch(c_PC_A);
        expect_c("ctr_one", 1, 0, c_TGT_A, 5, 3);

        // 4: aliasing PC evicts only on taken
        resolve(c_PC_A, c_PC_B, c_TGT_B, 1'b0, 1'b0);
        fetch(c_PC_A);
        expect_c("alias_nt", 1, 0, c_TGT_A, 6, 3);
        resolve(c_PC_A, c_PC_B, c_TGT_B, 1'b0, 1'b1);
        fetch(c_PC_A);
        expect_c("alias_evict", 0, 0, 0, 7, 4);
        fetch(c_PC_B);
        expect_c("alias_new", 1, 1, c_TGT_B, 7, 4);

        // 5: invalidate beats a simultaneous allocation; stats still count
        step(1'b1, c_PC_B, 1'b1, c_PC_C, 32'h0000_0123, 1'b0, 1'b1, 1'b1);
        fetch(c_PC_C);
        expect_c("inv_new", 0, 0, 0, 8, 5);
        fetch(c_PC_B);
        expect_c("inv_old", 0, 0, 0, 8, 5);

        // 6: saturation, then reset pulse with a concurrent resolution
        for (int i = 0; i < 20; i++) resolve(c_PC_A, c_PC_A, c_TGT_A, 1'b0, 1'b1);
        fetch(c_PC_A);
        expect_c("saturate", 1, 1, c_TGT_A, 15, 15);
        step(1'b0, c_PC_A, 1'b1, c_PC_B, c_TGT_B, 1'b0, 1'b1, 1'b0);
        fetch(c_PC_A);
        expect_c("rst_a", 0, 0, 0, 0, 0);
        fetch(c_PC_B);
        expect_c("rst_b", 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 299) != 0), rand_pc(), $urandom_range(0, 1) == 1,
                 rand_pc(), $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 39) == 0);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
